pipeline_output_collector: RTL and testbench
============================================

// Module: pipeline_output_collector
//
// PURPOSE
//   Receive-side endpoint for a stitched valid-only pipeline, which has no backpressure.
//   Sits at the pipeline output and buffers results in a DEPTH-entry FIFO.
//   Presents the results downstream as ready/valid.
//   Throttles upstream issue with credits so that nothing issued can ever be dropped.
//
// PARAMETERS
//   DATA_WIDTH  32  width of pipeline result / out_data
//   DEPTH        4  FIFO entries and total credits; legal range 1..255
//                   full throughput requires DEPTH >= LATENCY+1
//   LATENCY      3  pipeline issue->result cycles; informational only, used by bench checks
//
// PORTS
//   clk          in   1           sole clock, rising edge
//   rst          in   1           asynchronous, active-high reset; must be shared with the pipeline
//   in_ready     out  1           upstream may assert the pipeline's input_valid this cycle
//   issue_valid  in   1           tap of the pipeline's input_valid (issue event)
//   pipe_valid   in   1           pipeline final-stage valid
//   pipe_data    in   DATA_WIDTH  pipeline final-stage data
//   out_valid    out  1           downstream result available
//   out_ready    in   1           downstream accepts; a pop happens when out_valid && out_ready
//   out_data     out  DATA_WIDTH  head result; held stable while out_valid && !out_ready
//   occupancy    out  8           current number of FIFO entries
//   err          out  1           sticky protocol-violation flag
//
// BEHAVIOUR
//   - Reset values: in_ready=1, out_valid=0, out_data=0, occupancy=0, err=0.
//     Reset also clears internal state: inflight=0, rd_ptr=0, wr_ptr=0.
//   - Credit accounting: credits = DEPTH - occupancy - inflight (all regs, 8 bit).
//     in_ready = (credits != 0), taken from registered state only (no comb path from inputs).
//   - inflight counter update:
//     - +1 on issue_valid.
//     - -1 on pipe_valid.
//     - Both in the same cycle: unchanged.
//   - Push: pipe_valid writes pipe_data at wr_ptr; wr_ptr increments, wrapping DEPTH-1 -> 0.
//   - Pop: out_valid && out_ready increments rd_ptr (same wrap).
//   - Simultaneous push and pop: occupancy unchanged, both pointers advance.
//   - Output timing: out_valid = (occupancy != 0). out_data = mem[rd_ptr] (FWFT).
//     Latency pipe_valid -> out_valid is 1 cycle.
//   - Pop when empty: impossible, because out_valid=0.
//   - Push when occupancy==DEPTH: unreachable under the credit rules. If it happens anyway:
//     data is dropped, pointers and occupancy are unchanged, err is set.
//   - err is set on any of the following, and is cleared only by rst:
//     - issue_valid while in_ready==0
//     - pipe_valid while inflight==0 (and no same-cycle issue)
//     - the overflow push described above
//   - Counter saturation: counters never wrap. inflight does not go below 0 or above DEPTH.
//   - Reset mid-operation: all state clears. Pipeline valids clear on the same rst, so no stale result arrives.
//
// CONFIGURATION
//   COLLECTOR_BYPASS_EN defined:
//     - If occupancy==0 && pipe_valid && out_ready: out_valid=1 and out_data=pipe_data combinationally.
//     - That entry is consumed without being pushed. Latency is 0 cycles.
//     - If out_ready=0, the normal push path applies.
//   COLLECTOR_BYPASS_EN undefined:
//     - No path from pipe_* to out_*. Every result is pushed; latency is exactly 1 cycle.
//
// TESTING (DEPTH=4, LATENCY=3, DATA_WIDTH=32)
//   1. Streaming: rst, then issue every cycle with out_ready=1 and pipe_valid 3 cycles after each issue.
//      -> in_ready stays 1, out_data follows issue order (1,2,3,...), err=0.
//   2. Stall: out_ready=0, issue until in_ready=0.
//      -> exactly 4 issues accepted, then occupancy=4 and in_ready=0.
//      Then raise out_ready -> 4 pops in order, and in_ready=1 the cycle after the first pop.
//   3. Simultaneous push and pop at occupancy=2 -> occupancy stays 2; wr_ptr and rd_ptr wrap 3->0 correctly.
//   4. Protocol errors:
//      - issue_valid with in_ready=0 -> err=1 next cycle.
//      - pipe_valid with inflight=0 after rst -> err=1.
//      - err holds until rst.
//   5. Async reset with occupancy=3, inflight=1 -> outputs take reset values immediately, without a clock edge.
//   6. Bypass: with COLLECTOR_BYPASS_EN, empty FIFO, pipe_valid=1, out_ready=1, pipe_data=32'hDEAD_BEEF
//      -> out_valid=1 and out_data=32'hDEAD_BEEF the same cycle, occupancy stays 0.
//      Without the macro -> out_data appears one cycle later.

Source files
------------

// File: rtl/pipeline_output_collector.sv
// Credit-throttled result collector for a valid-only pipeline: buffers results in a
// DEPTH-entry FWFT FIFO and presents them ready/valid. Optional macro: COLLECTOR_BYPASS_EN.
module pipeline_output_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  in_ready,
  input  logic                  issue_valid,
  input  logic                  pipe_valid,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            occupancy,
  output logic                  err
);

  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]      DEPTH_C  = 8'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > 255 || LATENCY < 1) begin : g_param_check
    $error("pipeline_output_collector: illegal DEPTH or LATENCY");
  end

  logic [DATA_WIDTH-1:0] mem [0:(1<<PW)-1];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [7:0]            occ_q, inflight_q, credits;
  logic                  err_q;
  logic                  bypass, push, pop, overflow, wr_en;
  logic                  issue_err, orphan_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Every slot is either in the FIFO or promised to an issued result, so in_ready
  // depends on registered counts only and never on this cycle's inputs.
  assign credits  = DEPTH_C - occ_q - inflight_q;
  assign in_ready = (credits != 8'd0);

  // Downstream handshake: out_valid/out_data are held until out_ready is seen high
  // in the same cycle; a transfer (pop) occurs on out_valid && out_ready.
`ifdef COLLECTOR_BYPASS_EN
  assign bypass    = (occ_q == 8'd0) && pipe_valid && out_ready;
  assign out_valid = (occ_q != 8'd0) || bypass;
  assign out_data  = bypass ? pipe_data : mem[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = (occ_q != 8'd0);
  assign out_data  = mem[rd_ptr];
`endif

  assign pop        = (occ_q != 8'd0) && out_ready;
  assign push       = pipe_valid && !bypass;
  assign overflow   = push && (occ_q == DEPTH_C) && !pop;
  assign wr_en      = push && !overflow;
  assign issue_err  = issue_valid && !in_ready;
  assign orphan_err = pipe_valid && (inflight_q == 8'd0) && !issue_valid;

  assign occupancy = occ_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ_q      <= 8'd0;
      inflight_q <= 8'd0;
      err_q      <= 1'b0;
      for (int i = 0; i < (1 << PW); i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= pipe_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      if (wr_en && !pop)      occ_q <= occ_q + 8'd1;
      else if (pop && !wr_en) occ_q <= occ_q - 8'd1;

      // Saturating: an illegal issue or orphan result flags err instead of wrapping.
      if (issue_valid && !pipe_valid && inflight_q != DEPTH_C)
        inflight_q <= inflight_q + 8'd1;
      else if (pipe_valid && !issue_valid && inflight_q != 8'd0)
        inflight_q <= inflight_q - 8'd1;

      if (issue_err || orphan_err || overflow) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_output_collector.sv
// Directed bench for pipeline_output_collector (DEPTH=4, LATENCY=3, DATA_WIDTH=32).
// Results are driven PIPE_GAP input cycles after their issue, as a LATENCY-stage pipeline would.
module tb_pipeline_output_collector;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int LATENCY    = 3;
  localparam int PIPE_GAP   = LATENCY - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_ready;
  logic                  issue_valid = 1'b0;
  logic                  pipe_valid  = 1'b0;
  logic [DATA_WIDTH-1:0] pipe_data   = '0;
  logic                  out_valid;
  logic                  out_ready   = 1'b0;
  logic [DATA_WIDTH-1:0] out_data;
  logic [7:0]            occupancy;
  logic                  err;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];

  pipeline_output_collector #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .issue_valid(issue_valid),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // driver
  task automatic drive(input logic iv, input logic pv, input logic [DATA_WIDTH-1:0] pd,
                       input logic ordy);
    issue_valid = iv;
    pipe_valid  = pv;
    pipe_data   = pv ? pd : '0;
    out_ready   = ordy;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  int t3_occ [8] = '{0, 0, 1, 2, 2, 2, 1, 0};
  int t3_dat [8] = '{0, 0, 21, 21, 22, 23, 24, 0};

  initial begin
    // reset state
    drive(1'b0, 1'b0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1. streaming: six issues, results land two input cycles later, always drained
    for (int c = 0; c < 9; c++) begin
      drive(c < 6, (c >= PIPE_GAP) && (c < 6 + PIPE_GAP), 32'(c - PIPE_GAP + 1), 1'b1);
      tick();
      chk("stream_in_ready", in_ready, 1);
      chk("stream_err", err, 0);
      if (c >= PIPE_GAP && c < 6 + PIPE_GAP) begin
        chk("stream_out_valid", out_valid, 1);
        chk("stream_out_data", out_data, 32'(c - PIPE_GAP + 1));
      end
    end
    chk("stream_end_occ", occupancy, 0);
    chk("stream_end_valid", out_valid, 0);

    // 2. stall: out_ready low, issue until credits run out
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        chk("stall_in_ready_before_issue", in_ready, 1);
        exp_q.push_back(32'(11 + c));
      end
      drive(c < 4, c >= 2, 32'(9 + c), 1'b0);
      tick();
      if (c == 3) chk("stall_in_ready_exhausted", in_ready, 0);
    end
    chk("stall_occ_full", occupancy, 4);
    chk("stall_in_ready_full", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_head", out_data, exp_q[0]);
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    chk("stall_hold_data", out_data, exp_q[0]);
    chk("stall_hold_occ", occupancy, 4);
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      chk("drain_data", out_data, exp_q[0]);
      void'(exp_q.pop_front());
      tick();
      chk("drain_occ", occupancy, 32'(3 - p));
      chk("drain_in_ready", in_ready, 1);
    end
    chk("drain_out_valid", out_valid, 0);

    // 3. simultaneous push/pop at occupancy 2 across pointer wrap
    for (int c = 0; c < 8; c++) begin
      if (c < 4) chk("wrap_in_ready", in_ready, 1);
      drive(c < 4, (c >= 2) && (c < 6), 32'(19 + c), c >= 4);
      tick();
      chk("wrap_occ", occupancy, 32'(t3_occ[c]));
      if (t3_occ[c] != 0) chk("wrap_data", out_data, 32'(t3_dat[c]));
    end
    chk("wrap_out_valid", out_valid, 0);
    chk("wrap_err", err, 0);

    // 4a. issue while in_ready=0
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, c >= 2, 32'(40 + c), 1'b0);
      tick();
    end
    chk("err_pre_in_ready", in_ready, 0);
    chk("err_pre_err", err, 0);
    drive(1'b1, 1'b1, 32'd44, 1'b0);
    tick();
    chk("err_issue_overrun", err, 1);
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    chk("err_issue_sticky", err, 1);
    async_reset();
    chk("err_cleared_by_rst", err, 0);

    // 4b. result with nothing in flight
    drive(1'b0, 1'b1, 32'd99, 1'b1);
    tick();
    chk("err_orphan", err, 1);
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    chk("err_orphan_sticky", err, 1);
    async_reset();
    chk("err_orphan_cleared", err, 0);

    // 5. asynchronous reset with occupancy=3, inflight=1
    for (int c = 0; c < 5; c++) begin
      drive(c < 4, c >= 2, 32'(48 + c), 1'b0);
      tick();
    end
    chk("arst_pre_occ", occupancy, 3);
    chk("arst_pre_in_ready", in_ready, 0);
    chk("arst_pre_data", out_data, 50);
    drive(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_err", err, 0);
    #1 rst = 1'b0;

    // 6. result arriving at an empty FIFO with out_ready high
    drive(1'b1, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    #1;
`ifdef COLLECTOR_BYPASS_EN
    chk("bypass_same_valid", out_valid, 1);
    chk("bypass_same_data", out_data, 32'hDEAD_BEEF);
`else
    chk("nobypass_same_valid", out_valid, 0);
`endif
    chk("bypass_same_occ", occupancy, 0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
`ifdef COLLECTOR_BYPASS_EN
    chk("bypass_next_occ", occupancy, 0);
    chk("bypass_next_valid", out_valid, 0);
`else
    chk("nobypass_next_occ", occupancy, 1);
    chk("nobypass_next_valid", out_valid, 1);
    chk("nobypass_next_data", out_data, 32'hDEAD_BEEF);
`endif
    tick();
    chk("bypass_final_occ", occupancy, 0);
    chk("bypass_final_err", err, 0);
    chk("bypass_final_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
